// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder slice: FSM state
// encoding, data word width and latency counter width.
package dmem_pkg;

  localparam int DMEM_WORD_WIDTH = 32;
  localparam int DMEM_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_memory_array.sv
// data_memory_array
// Synchronous single-port word array with a registered read port.
//   clk_i    : clock
//   rst_ni   : async active-low reset (clears only the read register)
//   en_i     : access enable for this cycle
//   we_i     : 1 = write wdata_i into index_i, 0 = read index_i
//   index_i  : word index
//   wdata_i  : write data
//   rdata_o  : registered read data; on a write it takes the written word
module data_memory_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [ADDR_WIDTH-1:0]      index_i,
  input  logic [DMEM_WORD_WIDTH-1:0] wdata_i,
  output logic [DMEM_WORD_WIDTH-1:0] rdata_o
);

  logic [DMEM_WORD_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // Storage has no reset. Writes are suppressed while reset is asserted so
  // a request presented during reset can never land in the array.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i && rst_ni) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  // Write-first read register: a write returns the word just stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (en_i) begin
      rdata_o <= we_i ? wdata_i : mem_q[index_i];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Backing data memory behind the data cache. Accepts one word read or write
// at a time, holds it for LATENCY cycles, then presents the response until
// the requester takes it.
//   clk_i / rst_ni            : clock, async active-low reset
//   req_valid_i / req_ready_o : request handshake (ready only in IDLE)
//   req_write_i               : 1 = write, 0 = read
//   mem_address_i             : byte address, bits [ADDR_WIDTH+1:2] used
//   data_in_i                 : write data
//   rsp_valid_o / rsp_ready_i : response handshake
//   data_out_o                : read data, or the written word for a write
// Optional feature macro DATA_MEMORY_RESPONDER_STATS_EN adds
//   read_count_o / write_count_o : accepted read / write counters
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] data_in_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] data_out_o
`ifdef DATA_MEMORY_RESPONDER_STATS_EN
  ,
  output logic [31:0] read_count_o,
  output logic [31:0] write_count_o
`endif
);

  localparam logic [DMEM_CNT_WIDTH-1:0] LAT_M1  = DMEM_CNT_WIDTH'(LATENCY - 1);
  localparam logic [DMEM_CNT_WIDTH-1:0] CNT_ONE = DMEM_CNT_WIDTH'(1);

  dmem_state_e state_q, state_d;
  logic [DMEM_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       write_q;
  logic [DMEM_WORD_WIDTH-1:0] wdata_q;

  logic                       accept;
  logic                       mem_en;
  logic [ADDR_WIDTH-1:0]      mem_index;
  logic                       mem_we;
  logic [DMEM_WORD_WIDTH-1:0] mem_wdata;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address_i[31:ADDR_WIDTH+2], mem_address_i[1:0]};

  assign accept = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance; later input changes have no effect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= mem_address_i[ADDR_WIDTH+1:2];
      write_q <= req_write_i;
      wdata_q <= data_in_i;
    end
  end

  // mem_en marks the RESP-entry edge; that is the only cycle the array is
  // touched, so an aborted request never commits a write.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en      = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            mem_en  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          mem_en  = 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the RESP-entry edge is the acceptance edge, before the
  // capture registers are loaded, so the live request is used in IDLE.
  always_comb begin
    mem_index = addr_q;
    mem_we    = write_q;
    mem_wdata = wdata_q;
    if (state_q == IDLE) begin
      mem_index = mem_address_i[ADDR_WIDTH+1:2];
      mem_we    = req_write_i;
      mem_wdata = data_in_i;
    end
  end

  data_memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .index_i (mem_index),
    .wdata_i (mem_wdata),
    .rdata_o (data_out_o)
  );

`ifdef DATA_MEMORY_RESPONDER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_count_o  <= '0;
      write_count_o <= '0;
    end else if (accept) begin
      if (req_write_i) begin
        write_count_o <= write_count_o + 32'd1;
      end else begin
        read_count_o <= read_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
// Two responders share one stimulus port: dut_a (LATENCY=3) and dut_b
// (LATENCY=1); `sel` routes requests and selects which outputs are observed.
// Expected responses are queued at issue and checked by an independent monitor.
module tb_data_memory_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int AW    = 10;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] data_in   = '0;
  logic        rsp_ready = 1'b0;

  logic        a_req_valid, a_req_ready, a_rsp_valid;
  logic        b_req_valid, b_req_ready, b_rsp_valid;
  logic [31:0] a_data_out, b_data_out;
  logic        req_ready, rsp_valid;
  logic [31:0] data_out;
`ifdef DATA_MEMORY_RESPONDER_STATS_EN
  logic [31:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid &  sel;
  assign req_ready   = sel ? b_req_ready : a_req_ready;
  assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
  assign data_out    = sel ? b_data_out  : a_data_out;

  data_memory_responder #(.LATENCY(LAT_A), .ADDR_WIDTH(AW)) dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (a_req_valid),
    .req_ready_o   (a_req_ready),
    .req_write_i   (req_write),
    .mem_address_i (mem_addr),
    .data_in_i     (data_in),
    .rsp_valid_o   (a_rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .data_out_o    (a_data_out)
`ifdef DATA_MEMORY_RESPONDER_STATS_EN
    ,
    .read_count_o  (a_rd_cnt),
    .write_count_o (a_wr_cnt)
`endif
  );

  data_memory_responder #(.LATENCY(LAT_B), .ADDR_WIDTH(AW)) dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (b_req_valid),
    .req_ready_o   (b_req_ready),
    .req_write_i   (req_write),
    .mem_address_i (mem_addr),
    .data_in_i     (data_in),
    .rsp_valid_o   (b_rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .data_out_o    (b_data_out)
`ifdef DATA_MEMORY_RESPONDER_STATS_EN
    ,
    .read_count_o  (b_rd_cnt),
    .write_count_o (b_wr_cnt)
`endif
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model[int];
  int          written[$];
  int          checks = 0;
  int          errors = 0;
  int          expRd[2];
  int          expWr[2];
  int          readyMode = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response-ready driver: 0 = always ready, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: latency, data, stability under backpressure, and return to idle.
  bit          prevValid = 0;
  bit          hsPending = 0;
  logic [31:0] heldData  = '0;
  always @(negedge clk) begin
    if (!rst_ni) begin
      prevValid = 0;
      hsPending = 0;
    end else begin
      if (hsPending) begin
        checkOutput("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        hsPending = 0;
      end
      if (rsp_valid) begin
        checkOutput("busy_req_ready", {31'd0, req_ready}, 32'd0);
        if (!prevValid) begin
          if (expQ.size() == 0) begin
            failNow("unexpected_response");
          end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rsp_latency", cyc, e.cyc);
            if (e.chk) checkOutput("rsp_data", data_out, e.data);
            heldData = data_out;
          end
        end else begin
          checkOutput("rsp_data_stable", data_out, heldData);
        end
        if (rsp_ready) hsPending = 1;
      end
      prevValid = rsp_valid;
    end
  end

  function automatic int wordKey(input logic [31:0] addr);
    return int'(sel) * (1 << AW) + int'((addr >> 2) & ((1 << AW) - 1));
  endfunction

  // Issue one request; the model decides the expected response from the
  // word-index rule alone. commit=0 means the write will be aborted.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input bit commit);
    int   waited = 0;
    int   key;
    exp_t e;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      failNow("req_ready_timeout");
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    mem_addr  = addr;
    data_in   = data;
    key       = wordKey(addr);
    e.cyc     = cyc + (sel ? LAT_B : LAT_A);
    if (wr) begin
      e.data = data;
      e.chk  = 1'b1;
      if (commit) begin
        model[key] = data;
        written.push_back(key);
      end
      expWr[sel]++;
    end else begin
      e.chk  = model.exists(key);
      e.data = e.chk ? model[key] : 32'd0;
      expRd[sel]++;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    mem_addr  = $urandom;
    data_in   = $urandom;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while ((expQ.size() != 0 || rsp_valid) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (expQ.size() != 0 || rsp_valid) begin
      failNow("drain_timeout");
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    expQ.delete();
    expRd = '{0, 0};
    expWr = '{0, 0};
    rst_ni = 1'b1;
  endtask

  task automatic checkStats();
`ifdef DATA_MEMORY_RESPONDER_STATS_EN
    checkOutput("a_read_count",  a_rd_cnt, 32'(expRd[0]));
    checkOutput("a_write_count", a_wr_cnt, 32'(expWr[0]));
    checkOutput("b_read_count",  b_rd_cnt, 32'(expRd[1]));
    checkOutput("b_write_count", b_wr_cnt, 32'(expWr[1]));
`endif
  endtask

  task automatic randomPhase(input int n);
    logic [31:0] addr;
    logic [31:0] tmp;
    int          key;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        applyStimulus(1'b1, $urandom, $urandom, 1'b1);
      end else begin
        key  = written[$urandom_range(0, written.size() - 1)] % (1 << AW);
        tmp  = $urandom;
        addr = (tmp & 32'hFFFF_F003) | (32'(key) << 2);
        applyStimulus(1'b0, addr, 32'd0, 1'b1);
      end
    end
    waitDrain();
  endtask

  initial begin
    // Reset values of both responders
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("rst_a_req_ready", {31'd0, a_req_ready}, 32'd1);
    checkOutput("rst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    checkOutput("rst_a_data_out",  a_data_out, 32'd0);
    checkOutput("rst_b_req_ready", {31'd0, b_req_ready}, 32'd1);
    checkOutput("rst_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    checkOutput("rst_b_data_out",  b_data_out, 32'd0);
    checkStats();

    // Write then read, LATENCY=3
    readyMode = 0;
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 1'b1);
    waitDrain();

    // Backpressure: response held for five cycles
    readyMode = 2;
    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 1'b1);
    begin
      int waited = 0;
      while (!rsp_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!rsp_valid) failNow("bp_valid_timeout");
    end
    repeat (5) @(negedge clk);
    checkOutput("bp_data_held", data_out, 32'hDEAD_BEEF);
    readyMode = 0;
    waitDrain();

    // Aliasing: 0x1004 and 0x0005 both index word 1
    applyStimulus(1'b1, 32'h0000_1004, 32'h0000_1234, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 32'h0000_0005, 32'd0, 1'b1);
    waitDrain();

    // Reset mid-WAIT: aborted write of word 2 must not commit
    applyStimulus(1'b1, 32'h0000_0008, 32'h0000_5555, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 32'h0000_0008, 32'h0000_AAAA, 1'b0);
    doReset();
    @(negedge clk);
    checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrst_data_out",  data_out, 32'd0);
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 32'h0000_0008, 32'd0, 1'b1);
    waitDrain();

    // Random traffic on the LATENCY=3 responder
    readyMode = 1;
    randomPhase(40);
    checkStats();

    // LATENCY=1 responder: 2 writes, 3 reads, then random traffic
    readyMode = 0;
    sel = 1'b1;
    written.delete();
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0028, 32'h1111_0011, 1'b1);
    applyStimulus(1'b1, 32'h0000_002C, 32'h2222_0022, 1'b1);
    applyStimulus(1'b0, 32'h0000_0028, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h0000_002C, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_F02B, 32'd0, 1'b1);
    waitDrain();
    checkStats();
    readyMode = 1;
    randomPhase(40);
    checkStats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the data-cache miss/fill path. It accepts one word read or write request at a time over a valid/ready handshake, holds it for a fixed access latency, and returns a response over a second valid/ready handshake. It models the backing data memory behind the direct-mapped data cache, so cache fill and write traffic sees realistic multi-cycle timing.

## Interface
- `LATENCY`, 3: cycles from request acceptance to first response-valid cycle; legal range 1..15.
- `ADDR_WIDTH`, 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.

- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: responder can accept a request; high only in IDLE.
- `req_write_i` in 1: 1 = write, 0 = read.
- `mem_address_i` in 32: byte address; bits [ADDR_WIDTH+1:2] index the array; all other bits ignored.
- `data_in_i` in 32: write data.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: requester takes the response.
- `data_out_o` out 32: read data, or the written word for a write.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: `req_ready_o`=1. When `req_valid_i` is high, capture the address, write flag and data. If LATENCY==1, go to RESP. Otherwise go to WAIT and load the counter with LATENCY-1.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP.
- Entry edge into RESP: a write commits `data_in` (captured value) to the array and `data_out_o` gets that value. A read registers the array word into `data_out_o`.
- RESP: `rsp_valid_o`=1. `data_out_o` holds stable until `rsp_ready_i` is high, then the FSM returns to IDLE.
- Request inputs are ignored outside IDLE. Captured values are used, so input changes after acceptance have no effect.
- The array is not cleared by reset. Reads of never-written words return X in simulation.
- Address aliasing is intentional: addresses differing only above bit ADDR_WIDTH+1 or in bits [1:0] hit the same word.

## Timing
- Acceptance cycle T is the cycle where `req_valid_i` and `req_ready_o` are both sampled high.
- `rsp_valid_o` first high in cycle T+LATENCY.
- Handshake in cycle R (`rsp_valid_o`&`rsp_ready_i`): `rsp_valid_o`=0 and `req_ready_o`=1 in cycle R+1. There are no back-to-back requests, so peak throughput is one per LATENCY+1 cycles.
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `data_out_o`=0, counter=0.
- Reset asserted mid-operation: immediate return to IDLE with no response.
  - A write whose RESP-entry edge has not occurred is not committed.
  - A write already committed stays in the array.
- Holding `rsp_ready_i` high permanently is legal. The response then lasts exactly one cycle.

## Configuration
- `DATA_MEMORY_RESPONDER_STATS_EN` defined:
  - Adds outputs `read_count_o` and `write_count_o`, 32 bits each, reset to 0.
  - Each increments by 1 in the cycle after an accepted read or write respectively, and wraps at 2^32.
- `DATA_MEMORY_RESPONDER_STATS_EN` undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum `dmem_state_e` (IDLE, WAIT, RESP);
  - `DMEM_WORD_WIDTH`=32;
  - the counter width constant (4 bits).
- Sub-module `data_memory_array` is a synchronous single-port word array, parameterised by ADDR_WIDTH, with write enable, index, write data and a registered read. The FSM drives its enables on the RESP-entry edge.

## Test plan
- Reset: hold `rst_ni`=0 then release. Required: `req_ready_o`=1, `rsp_valid_o`=0, `data_out_o`=0, and stats counters 0 when enabled.
- Write then read, LATENCY=3: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010. Required:
  - each `rsp_valid_o` rises exactly 3 cycles after its acceptance;
  - the write response carries 0xDEADBEEF;
  - the read returns 0xDEADBEEF.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles during a read. Required: `rsp_valid_o` and `data_out_o` stay stable, `req_ready_o`=0 throughout, and IDLE follows 1 cycle after `rsp_ready_i` rises.
- Aliasing, ADDR_WIDTH=10: write 0x1234 to 0x0000_1004, then read 0x0000_0005. Required: the read returns 0x1234, since both addresses index word 1.
- Reset mid-WAIT: assert reset one cycle after accepting a write of 0xAAAA to word 2, which previously held 0x5555. Required: no response, and a later read of word 2 returns 0x5555.
- LATENCY=1 with the stats macro on: issue 3 reads and 2 writes. Required: each response is valid 1 cycle after acceptance, and finally `read_count_o`=3 and `write_count_o`=2.
